instr_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a request/ready instruction-memory interface that tolerates variable latency.
- Presents one fetched instruction plus PC+4 to IF/ID, honours stalls and branch/jump redirects from ID, and stops fetching on the halt word.

---
 rtl/instr_fetch_pkg.sv | 31 +++
 rtl/instr_fetch.sv | 134 +++++++++++++
 tb/tb_instr_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package instr_fetch_pkg;

    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [INSTR_WIDTH-1:0] NOP           = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0]    PC_STEP       = 32'd4;
    localparam logic [PC_WIDTH-1:0]    PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_HALT  = 2'd2
    } if_state_e;

    // Payload presented to the IF/ID register
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] ins;
        logic [PC_WIDTH-1:0]    pc_plus4;
        logic                   valid;
    } ifid_t;

    // Force a PC onto a word boundary
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues variable-latency imem
// requests, handles stalls/redirects from ID and stops on the halt word.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic                   CLOCK,
    input  logic                   RESET_N,
    input  logic                   StallF,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] ins,
    output logic [PC_WIDTH-1:0]    PCPlus4F,
    output logic                   ins_valid,
    output logic                   halted
);

    localparam logic [PC_WIDTH-1:0] RESET_PC_A  = align_pc(RESET_PC);
    localparam logic [PC_WIDTH-1:0] RESET_PC_P4 = RESET_PC_A + PC_STEP;

    if_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  req_q, req_d;
    logic                  redir_pend_q, redir_pend_d;
    logic [PC_WIDTH-1:0]   redir_pc_q, redir_pc_d;
    logic                  halted_q, halted_d;
    ifid_t                 ifid_q, ifid_d;
    logic [PC_WIDTH-1:0]   redirect_pc_a;

    assign redirect_pc_a = align_pc(redirect_pc);

    // State and datapath registers; reset drops any outstanding request
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC_A;
            req_q        <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= RESET_PC_A;
            halted_q     <= 1'b0;
            ifid_q       <= '{ins: NOP, pc_plus4: RESET_PC_P4, valid: 1'b0};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            halted_q     <= halted_d;
            ifid_q       <= ifid_d;
        end
    end

    // Next-state logic; req_q low in FETCH means no request is outstanding
    // yet (first cycle after reset), so imem_ready is ignored there.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = 1'b0;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        halted_d     = halted_q;
        ifid_d       = '{ins: NOP, pc_plus4: ifid_q.pc_plus4, valid: 1'b0};

        case (state_q)
            ST_FETCH: begin
                req_d = 1'b1;
                if (req_q && imem_ready) begin
                    if (redirect || redir_pend_q) begin
                        // Wrong-path response: drop it and refetch at the target
                        pc_d         = redirect ? redirect_pc_a : redir_pc_q;
                        redir_pend_d = 1'b0;
                    end else if (imem_rdata == HALT_WORD) begin
                        state_d  = ST_HALT;
                        req_d    = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_VALID;
                        req_d   = 1'b0;
                        ifid_d  = '{ins: imem_rdata, pc_plus4: pc_q + PC_STEP, valid: 1'b1};
                    end
                end else if (redirect) begin
                    if (req_q) begin
                        // Keep the outstanding address stable; remember the target
                        redir_pend_d = 1'b1;
                        redir_pc_d   = redirect_pc_a;
                    end else begin
                        pc_d = redirect_pc_a;
                    end
                end
            end

            ST_VALID: begin
                if (redirect) begin
                    pc_d    = redirect_pc_a;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                end else if (StallF) begin
                    ifid_d = ifid_q;
                end else begin
                    pc_d    = ifid_q.pc_plus4;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                end
            end

            ST_HALT: begin
                if (redirect) begin
                    halted_d = 1'b0;
                    pc_d     = redirect_pc_a;
                    state_d  = ST_FETCH;
                    req_d    = 1'b1;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ins       = ifid_q.ins;
    assign PCPlus4F  = ifid_q.pc_plus4;
    assign ins_valid = ifid_q.valid;
    assign halted    = halted_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a bench-side memory serves requests,
// expected IF/ID payloads are queued on response and checked on ins_valid.
module tb_instr_fetch;

    logic        CLOCK;
    logic        RESET_N;
    logic        StallF;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic [31:0] PCPlus4F;
    logic        ins_valid;
    logic        halted;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_v;
    int   n_cmp;
    int   n_err;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .StallF      (StallF),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ins         (ins),
        .PCPlus4F    (PCPlus4F),
        .ins_valid   (ins_valid),
        .halted      (halted)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Monitor: pop on each new valid instruction, and NOP whenever not valid
    always @(negedge CLOCK) begin
        if (!RESET_N) begin
            prev_v = 1'b0;
        end else begin
            if (ins_valid === 1'b1 && prev_v !== 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: ins=%h pc4=%h with empty scoreboard", ins, PCPlus4F);
                end else begin
                    mon_e = sb.pop_front();
                    if (ins !== mon_e.ins || PCPlus4F !== mon_e.pc4) begin
                        n_err++;
                        $display("FAIL sb_payload: got ins=%h pc4=%h expected ins=%h pc4=%h",
                                 ins, PCPlus4F, mon_e.ins, mon_e.pc4);
                    end
                end
            end
            if (ins_valid === 1'b0) begin
                n_cmp++;
                if (ins !== 32'h0) begin
                    n_err++;
                    $display("FAIL nop_when_invalid: ins=%h expected 00000000", ins);
                end
            end
            prev_v = ins_valid;
        end
    end

    // Wait for a request, check address, hold off `delay` cycles, then respond
    task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                         input int delay, input bit accept);
        int t;
        t = 0;
        while (imem_req !== 1'b1 && t < 20) begin
            @(negedge CLOCK);
            t++;
        end
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            n_err++;
            $display("FAIL serve_req: req=%b addr=%h expected req=1 addr=%h (waited %0d)",
                     imem_req, imem_addr, addr, t);
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge CLOCK);
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== addr || ins_valid !== 1'b0) begin
                n_err++;
                $display("FAIL serve_hold: req=%b addr=%h valid=%b expected 1/%h/0",
                         imem_req, imem_addr, ins_valid, addr);
            end
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        if (accept) sb.push_back('{ins: data, pc4: addr + 32'd4});
        @(negedge CLOCK);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic test_reset();
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        repeat (2) @(negedge CLOCK);
        n_cmp++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b0 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: req=%b valid=%b halted=%b expected 0/0/0",
                     imem_req, ins_valid, halted);
        end
        n_cmp++;
        if (ins !== 32'h0 || PCPlus4F !== 32'h4 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: ins=%h pc4=%h addr=%h expected 0/4/0",
                     ins, PCPlus4F, imem_addr);
        end
        RESET_N = 1'b1;
        serve(32'h0, 32'h2008_0005, 0, 1'b1);
        n_cmp++;
        if (ins_valid !== 1'b1 || ins !== 32'h2008_0005 || PCPlus4F !== 32'h4) begin
            n_err++;
            $display("FAIL reset_first: valid=%b ins=%h pc4=%h expected 1/20080005/4",
                     ins_valid, ins, PCPlus4F);
        end
        @(negedge CLOCK);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_err++;
            $display("FAIL reset_next_req: req=%b addr=%h expected 1/4", imem_req, imem_addr);
        end
    endtask

    task automatic test_latency();
        serve(32'h4, 32'h2129_0001, 3, 1'b1);
    endtask

    task automatic test_stall();
        StallF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK);
            n_cmp++;
            if (ins_valid !== 1'b1 || ins !== 32'h2129_0001 || PCPlus4F !== 32'h8 || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: valid=%b ins=%h pc4=%h req=%b expected 1/21290001/8/0",
                         i, ins_valid, ins, PCPlus4F, imem_req);
            end
        end
        StallF = 1'b0;
        @(negedge CLOCK);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_err++;
            $display("FAIL stall_release: req=%b addr=%h expected 1/8", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_pending();
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        @(negedge CLOCK);
        redirect_pc = 32'h40;
        @(negedge CLOCK);
        redirect = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || ins_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_hold: req=%b addr=%h valid=%b expected 1/8/0",
                     imem_req, imem_addr, ins_valid);
        end
        @(negedge CLOCK);
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge CLOCK);
        imem_ready = 1'b0;
        n_cmp++;
        if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL redir_discard: valid=%b req=%b addr=%h expected 0/1/40",
                     ins_valid, imem_req, imem_addr);
        end
        serve(32'h40, 32'h8C08_0000, 1, 1'b1);
    endtask

    task automatic test_halt();
        serve(32'h44, 32'hFFFF_FFFF, 0, 1'b0);
        n_cmp++;
        if (halted !== 1'b1 || ins_valid !== 1'b0 || ins !== 32'h0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL halt_enter: halted=%b valid=%b ins=%h req=%b expected 1/0/0/0",
                     halted, ins_valid, ins, imem_req);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h2000_0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK);
            n_cmp++;
            if (imem_req !== 1'b0 || halted !== 1'b1) begin
                n_err++;
                $display("FAIL halt_idle[%0d]: req=%b halted=%b expected 0/1", i, imem_req, halted);
            end
        end
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge CLOCK);
        redirect = 1'b0;
        n_cmp++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL halt_exit: halted=%b req=%b addr=%h expected 0/1/100",
                     halted, imem_req, imem_addr);
        end
        serve(32'h100, 32'h0000_0020, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 32'h104 + 32'(4 * i);
            @(negedge CLOCK);
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                n_err++;
                $display("FAIL b2b_req[%0d]: req=%b addr=%h expected 1/%h", i, imem_req, imem_addr, a);
            end
            serve(a, $urandom & 32'h7FFF_FFFF, 0, 1'b1);
        end
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge CLOCK);
        redirect = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || ins_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_redirect: req=%b addr=%h valid=%b expected 1/fffffffc/0",
                     imem_req, imem_addr, ins_valid);
        end
        serve(32'hFFFF_FFFC, 32'h0800_0000, 0, 1'b1);
        n_cmp++;
        if (PCPlus4F !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_pc4: pc4=%h expected 00000000", PCPlus4F);
        end
        @(negedge CLOCK);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_next: req=%b addr=%h expected 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        #2;
        RESET_N = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b0) begin
            n_err++;
            $display("FAIL areset_req: req=%b valid=%b expected 0/0", imem_req, ins_valid);
        end
        @(negedge CLOCK);
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_2222;
        RESET_N    = 1'b1;
        serve(32'h0, 32'hAC0A_0004, 0, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        n_cmp++;
        if (ins_valid !== 1'b0 || ins !== 32'h0 || PCPlus4F !== 32'h4 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL areset_valid: valid=%b ins=%h pc4=%h halted=%b expected 0/0/4/0",
                     ins_valid, ins, PCPlus4F, halted);
        end
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        prev_v      = 1'b0;
        RESET_N     = 1'b0;
        StallF      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;

        test_reset();
        test_latency();
        test_stall();
        test_redirect_pending();
        test_halt();
        test_back_to_back();
        test_wrap();
        test_async_reset();

        repeat (3) @(negedge CLOCK);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instr_fetch
